// File: rtl/bitwise_logic_iter.sv
// Iterative AND/OR/XOR/NOR engine: CHUNK bits per cycle, start/ready handshake, accumulate mode.
// Optional popcount output enabled with BITWISE_LOGIC_POPCOUNT_EN.
module bitwise_logic_iter #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_start,
   input  logic [1:0]       ctrl_op,
   input  logic             ctrl_accum,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_resultRDY,
   output logic             busy,
   output logic             data_zero
`ifdef BITWISE_LOGIC_POPCOUNT_EN
   ,
   output logic [$clog2(WIDTH):0] data_popcount
`endif
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [1:0]       op_sel;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] next_work;
   logic [CHUNK-1:0] chunk_a;
   logic [CHUNK-1:0] chunk_b;
   logic [CHUNK-1:0] chunk_res;
   logic             last;

   // Select the active chunk of the latched operands and merge its result into the working word.
   always_comb begin
      chunk_a   = '0;
      chunk_b   = '0;
      next_work = work;
      for (int k = 0; k < N; k++) begin
         if (count == CW'(k)) begin
            chunk_a = op_a[k*CHUNK +: CHUNK];
            chunk_b = op_b[k*CHUNK +: CHUNK];
         end
      end
      case (op_sel)
         2'b00:   chunk_res = chunk_a & chunk_b;
         2'b01:   chunk_res = chunk_a | chunk_b;
         2'b10:   chunk_res = chunk_a ^ chunk_b;
         default: chunk_res = ~(chunk_a | chunk_b);
      endcase
      for (int k = 0; k < N; k++) begin
         if (count == CW'(k)) begin
            next_work[k*CHUNK +: CHUNK] = chunk_res;
         end
      end
   end

   assign last      = (count == CW'(N - 1));
   assign data_zero = (data_result == '0);

`ifdef BITWISE_LOGIC_POPCOUNT_EN
   localparam int PW = $clog2(WIDTH) + 1;

   logic [PW-1:0] pop_acc;
   logic [PW-1:0] chunk_pop;

   // Per-chunk ones count keeps the adder narrow; the running total lives in pop_acc.
   always_comb begin
      chunk_pop = '0;
      for (int i = 0; i < CHUNK; i++) begin
         chunk_pop = chunk_pop + {{(PW-1){1'b0}}, chunk_res[i]};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pop_acc       <= '0;
         data_popcount <= '0;
      end else if (state == IDLE) begin
         pop_acc <= '0;
      end else begin
         pop_acc <= pop_acc + chunk_pop;
         if (last) begin
            data_popcount <= pop_acc + chunk_pop;
         end
      end
   end
`endif

   // Operands are captured at start so input changes during RUN cannot disturb the result.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         count          <= '0;
         op_a           <= '0;
         op_b           <= '0;
         op_sel         <= 2'b00;
         work           <= '0;
         data_result    <= '0;
         data_resultRDY <= 1'b0;
         busy           <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         case (state)
            IDLE: begin
               if (ctrl_start) begin
                  op_a   <= ctrl_accum ? data_result : data_operandA;
                  op_b   <= data_operandB;
                  op_sel <= ctrl_op;
                  count  <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               work <= next_work;
               if (last) begin
                  data_result    <= next_work;
                  data_resultRDY <= 1'b1;
                  busy           <= 1'b0;
                  count          <= '0;
                  state          <= IDLE;
               end else begin
                  count <= count + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
